// File: rtl/ula_sequenciador.sv
// Serial ALU sequencer: fetches an instruction, reads two operands from a
// four-entry register file, drives an external ALU and writes the result back.
module ula_sequenciador #(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [7:0] entrada1,
  output logic [7:0] entrada2,
  output logic [1:0] ULAop,
  input  logic [7:0] Resultado,
  input  logic       Zero,
  output logic       done,
  output logic       erro,
  output logic       flag_zero,
  input  logic [1:0] reg_sel,
  output logic [7:0] reg_dado
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEITURA  = 2'd1,
    EXECUCAO = 2'd2,
    ESCRITA  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [3:0][7:0] regFile_q, regFile_d;
  logic [3:0][7:0] regView;
  logic [7:0]      entrada1_q, entrada1_d;
  logic [7:0]      entrada2_q, entrada2_d;
  logic [1:0]      ulaOp_q, ulaOp_d;
  logic [7:0]      result_q, result_d;
  logic            done_q, done_d;
  logic            erro_q, erro_d;
  logic            flagZero_q, flagZero_d;

  logic [1:0] op, rd, rs, rt;
  logic       legal;

  assign op    = instr_q[7:6];
  assign rd    = instr_q[5:4];
  assign rs    = instr_q[3:2];
  assign rt    = instr_q[1:0];
  assign legal = (op != 2'b11);

  // With ZERO_R0 the hardwired zero is applied on every read path.
  always_comb begin
    regView = regFile_q;
    if (ZERO_R0) begin
      regView[0] = 8'h00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (instr_valid) state_d = LEITURA;
      LEITURA:  state_d = EXECUCAO;
      EXECUCAO: state_d = ESCRITA;
      ESCRITA:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    regFile_d  = regFile_q;
    entrada1_d = entrada1_q;
    entrada2_d = entrada2_q;
    ulaOp_d    = ulaOp_q;
    result_d   = result_q;
    flagZero_d = flagZero_q;
    done_d     = 1'b0;
    erro_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
        end
      end
      LEITURA: begin
        entrada1_d = regView[rs];
        entrada2_d = regView[rt];
        ulaOp_d    = legal ? op : 2'b00;
      end
      EXECUCAO: begin
        result_d = Resultado;
        if (legal) begin
          flagZero_d = Zero;
        end
      end
      ESCRITA: begin
        if (legal && !(ZERO_R0 && (rd == 2'd0))) begin
          regFile_d[rd] = result_q;
        end
        done_d = 1'b1;
        erro_d = !legal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q    <= 8'h00;
      regFile_q  <= '0;
      entrada1_q <= 8'h00;
      entrada2_q <= 8'h00;
      ulaOp_q    <= 2'b00;
      result_q   <= 8'h00;
      flagZero_q <= 1'b0;
      done_q     <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      regFile_q  <= regFile_d;
      entrada1_q <= entrada1_d;
      entrada2_q <= entrada2_d;
      ulaOp_q    <= ulaOp_d;
      result_q   <= result_d;
      flagZero_q <= flagZero_d;
      done_q     <= done_d;
      erro_q     <= erro_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign entrada1    = entrada1_q;
  assign entrada2    = entrada2_q;
  assign ULAop       = ulaOp_q;
  assign done        = done_q;
  assign erro        = erro_q;
  assign flag_zero   = flagZero_q;
  assign reg_dado    = regView[reg_sel];

endmodule

// File: tb/tb_ula_sequenciador.sv
// Scoreboard bench: two sequencers (ZERO_R0 = 0 and 1) share one instruction
// stream, each paired with a behavioural ALU, checked against a register-file model.
module tb_ula_sequenciador;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic [1:0] reg_sel = 2'd0;

  logic       instr_ready0, done0, erro0, flag_zero0, Zero0;
  logic [7:0] entrada1_0, entrada2_0, Resultado0, reg_dado0;
  logic [1:0] ULAop0;
  logic       instr_ready1, done1, erro1, flag_zero1, Zero1;
  logic [7:0] entrada1_1, entrada2_1, Resultado1, reg_dado1;
  logic [1:0] ULAop1;

  // Forcing the ALU result is the only way to get non-zero data into the registers.
  bit         overrideEn = 1'b0;
  logic [7:0] overrideVal = 8'h00;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastAccept = -1;

  typedef struct {
    int         acc;
    logic [7:0] old0, new0, old1, new1;
    logic [7:0] e1_0, e2_0, e1_1, e2_1;
    logic [1:0] ulaop;
    logic       erro, flag0, flag1;
  } expEntry_t;

  expEntry_t  sb[$];
  logic [7:0] m0[4];
  logic [7:0] m1[4];
  logic       mflag0, mflag1;

  function automatic logic [7:0] aluRef(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return (a < b) ? 8'd1 : 8'd0;
      2'b10:   return a & b;
      default: return 8'h00;
    endcase
  endfunction

  assign Resultado0 = overrideEn ? overrideVal : aluRef(ULAop0, entrada1_0, entrada2_0);
  assign Zero0      = (Resultado0 == 8'h00);
  assign Resultado1 = overrideEn ? overrideVal : aluRef(ULAop1, entrada1_1, entrada2_1);
  assign Zero1      = (Resultado1 == 8'h00);

  ula_sequenciador #(.ZERO_R0(1'b0)) dut0 (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready0), .entrada1(entrada1_0), .entrada2(entrada2_0),
    .ULAop(ULAop0), .Resultado(Resultado0), .Zero(Zero0), .done(done0),
    .erro(erro0), .flag_zero(flag_zero0), .reg_sel(reg_sel), .reg_dado(reg_dado0)
  );

  ula_sequenciador #(.ZERO_R0(1'b1)) dut1 (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready1), .entrada1(entrada1_1), .entrada2(entrada2_1),
    .ULAop(ULAop1), .Resultado(Resultado1), .Zero(Zero1), .done(done1),
    .erro(erro1), .flag_zero(flag_zero1), .reg_sel(reg_sel), .reg_dado(reg_dado1)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  // Monitor: every cycle checks readiness, mid-flight operands and the retire pulse.
  always @(negedge clock) begin : monitor
    expEntry_t e;
    int        diff;
    bit        readyWant;
    if (!reset) begin
      readyWant = (lastAccept < 0) || ((cycle - lastAccept) >= 3);
      checkOutput("instrReady0", int'(instr_ready0), int'(readyWant));
      checkOutput("instrReady1", int'(instr_ready1), int'(readyWant));
      if (sb.size() > 0 && (cycle - sb[0].acc) == 2) begin
        e = sb[0];
        checkOutput("entrada1_0", int'(entrada1_0), int'(e.e1_0));
        checkOutput("entrada2_0", int'(entrada2_0), int'(e.e2_0));
        checkOutput("entrada1_1", int'(entrada1_1), int'(e.e1_1));
        checkOutput("entrada2_1", int'(entrada2_1), int'(e.e2_1));
        checkOutput("ULAop0", int'(ULAop0), int'(e.ulaop));
        checkOutput("ULAop1", int'(ULAop1), int'(e.ulaop));
        checkOutput("regDadoBeforeWrite0", int'(reg_dado0), int'(e.old0));
        checkOutput("regDadoBeforeWrite1", int'(reg_dado1), int'(e.old1));
      end
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousDone", int'({done0, done1}), 0);
        end else begin
          e = sb.pop_front();
          diff = cycle - e.acc;
          checkOutput("doneLatency", diff, 3);
          checkOutput("done0", int'(done0), 1);
          checkOutput("done1", int'(done1), 1);
          checkOutput("erro0", int'(erro0), int'(e.erro));
          checkOutput("erro1", int'(erro1), int'(e.erro));
          checkOutput("flagZero0", int'(flag_zero0), int'(e.flag0));
          checkOutput("flagZero1", int'(flag_zero1), int'(e.flag1));
          checkOutput("regDadoAfterWrite0", int'(reg_dado0), int'(e.new0));
          checkOutput("regDadoAfterWrite1", int'(reg_dado1), int'(e.new1));
        end
      end else begin
        checkOutput("erroWithoutDone", int'({erro0, erro1}), 0);
        if (sb.size() > 0 && (cycle - sb[0].acc) >= 3) begin
          checkOutput("doneMissing", int'(done0), 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic sweepRegs();
    @(negedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i);
      #1;
      checkOutput($sformatf("regFile0[%0d]", i), int'(reg_dado0), int'(m0[i]));
      checkOutput($sformatf("regFile1[%0d]", i), int'(reg_dado1), (i == 0) ? 0 : int'(m1[i]));
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      checkOutput("idleTimeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Issues one instruction and records what both register files must look like.
  task automatic applyStimulus(input logic [7:0] ins, input bit hold);
    expEntry_t  e;
    bit         found;
    logic [1:0] op, rd, rs, rt;
    logic [7:0] a0, b0, a1, b1, res0, res1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (instr_ready0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checkOutput("readyTimeout", int'(instr_ready0), 1);
      return;
    end
    #1;
    op = ins[7:6]; rd = ins[5:4]; rs = ins[3:2]; rt = ins[1:0];
    a0 = m0[rs]; b0 = m0[rt];
    a1 = (rs == 2'd0) ? 8'h00 : m1[rs];
    b1 = (rt == 2'd0) ? 8'h00 : m1[rt];
    e.acc   = cycle + 1;
    e.e1_0  = a0; e.e2_0 = b0; e.e1_1 = a1; e.e2_1 = b1;
    e.ulaop = (op == 2'b11) ? 2'b00 : op;
    e.erro  = (op == 2'b11);
    e.old0  = m0[rd];
    e.old1  = (rd == 2'd0) ? 8'h00 : m1[rd];
    if (op != 2'b11) begin
      res0 = overrideEn ? overrideVal : aluRef(op, a0, b0);
      res1 = overrideEn ? overrideVal : aluRef(op, a1, b1);
      m0[rd] = res0;
      mflag0 = (res0 == 8'h00);
      if (rd != 2'd0) m1[rd] = res1;
      mflag1 = (res1 == 8'h00);
    end
    e.new0  = m0[rd];
    e.new1  = (rd == 2'd0) ? 8'h00 : m1[rd];
    e.flag0 = mflag0;
    e.flag1 = mflag1;
    sb.push_back(e);
    instr       = ins;
    instr_valid = 1'b1;
    reg_sel     = rd;
    lastAccept  = cycle + 1;
    @(posedge clock);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic preload(input logic [1:0] rd, input logic [7:0] val);
    instr_valid = 1'b0;
    waitIdle();
    overrideVal = val;
    overrideEn  = 1'b1;
    applyStimulus({2'b00, rd, 4'b0000}, 1'b0);
    waitIdle();
    overrideEn = 1'b0;
  endtask

  task automatic applyReset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    overrideEn  = 1'b0;
    sb.delete();
    lastAccept  = -1;
    for (int i = 0; i < 4; i++) begin
      m0[i] = 8'h00;
      m1[i] = 8'h00;
    end
    mflag0 = 1'b0;
    mflag1 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("resetDone", int'({done0, done1}), 0);
    checkOutput("resetErro", int'({erro0, erro1}), 0);
    checkOutput("resetFlagZero", int'({flag_zero0, flag_zero1}), 0);
    checkOutput("resetEntrada1", int'({entrada1_0, entrada1_1}), 0);
    checkOutput("resetEntrada2", int'({entrada2_0, entrada2_1}), 0);
    checkOutput("resetULAop", int'({ULAop0, ULAop1}), 0);
    checkOutput("resetReady", int'({instr_ready0, instr_ready1}), 3);
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i);
      #1;
      checkOutput($sformatf("resetReg[%0d]", i), int'({reg_dado0, reg_dado1}), 0);
    end
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    applyReset();

    // add r1 = r0 + r0 straight out of reset
    applyStimulus(8'h10, 1'b0);
    waitIdle();
    sweepRegs();

    // wrap-around add, then unsigned set-less-than into r0
    preload(2'd2, 8'hF0);
    preload(2'd3, 8'h20);
    applyStimulus(8'h1B, 1'b0);
    waitIdle();
    applyStimulus(8'h4E, 1'b0);
    waitIdle();
    sweepRegs();

    // illegal opcode
    applyStimulus(8'hFF, 1'b0);
    waitIdle();
    sweepRegs();

    // instr_valid held high across three back-to-back instructions
    applyStimulus(8'h1B, 1'b1);
    applyStimulus(8'h2E, 1'b1);
    applyStimulus(8'h97, 1'b0);
    waitIdle();
    sweepRegs();

    // reset while the add is in EXECUCAO
    preload(2'd2, 8'hF0);
    preload(2'd3, 8'h20);
    applyStimulus(8'h1B, 1'b0);
    @(negedge clock);
    @(negedge clock);
    #1;
    applyReset();
    sweepRegs();

    // AND into r0: non-zero and zero results
    preload(2'd2, 8'hF0);
    preload(2'd3, 8'h30);
    applyStimulus(8'h8B, 1'b0);
    waitIdle();
    sweepRegs();
    preload(2'd3, 8'h0F);
    applyStimulus(8'h8B, 1'b0);
    waitIdle();
    sweepRegs();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        preload(2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        applyStimulus(8'($urandom), $urandom_range(0, 1) == 1);
      end
    end
    instr_valid = 1'b0;
    waitIdle();
    sweepRegs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
